fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded when leaving IDLE; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 pc_out  output  32  address to instruction memory (combinational ROM, word-aligned, uses pc_out[7:2]).
REQ-006 imem_opcode  input  6  opcode field returned for pc_out, same cycle.
REQ-007 imem_funct  input  6  funct field returned for pc_out, same cycle.
REQ-008 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-009 redirect_target  input  32  new PC; bits [1:0] forced to 0.
REQ-010 if_ready  input  1  downstream decode accepts the output slot.
REQ-011 if_valid  output  1  output slot holds a fetched instruction.
REQ-012 if_pc  output  32  address of the instruction in the slot.
REQ-013 if_opcode  output  6  registered opcode of the slot.
REQ-014 if_funct  output  6  registered funct of the slot.
REQ-015 halted  output  1  high while in HALT.
REQ-016 fetch_count  output  16  number of accepted handshakes, saturating.

Function
REQ-017 FSM states SHALL be IDLE, RUN, HALT; encoding is free.
REQ-018 IDLE: pc_out=RESET_PC, if_valid=0; start=1 -> RUN with the first fetch in the following cycle.
REQ-019 RUN: slot free = !if_valid || if_ready; when free, the slot loads {pc_out, imem_opcode, imem_funct}, if_valid<=1, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
REQ-020 RUN with slot occupied and if_ready=0: slot, if_valid and pc SHALL hold unchanged.
REQ-021 Handshake: a transfer occurs when if_valid && if_ready; a slot SHALL never be dropped or duplicated.
REQ-022 Redirect in RUN: pc<=target&~3, if_valid<=0 (flush, including a slot being accepted that cycle, which still counts), no capture that cycle; first fetch from the target in the next cycle.
REQ-023 Redirect has priority over capture, over halt detection (REQ-029) and over start.
REQ-024 HALT: if_valid=0, pc holds, halted=1; redirect_valid -> RUN at target&~3; start ignored.
REQ-025 Redirect in IDLE SHALL be ignored.
REQ-026 fetch_count increments by 1 per transfer and holds at 16'hFFFF.
REQ-027 pc_out SHALL equal the internal PC register (no combinational path from any input).

Reset
REQ-028 rst_n=0 at a clock edge: state IDLE, pc=RESET_PC, if_valid=0, if_pc=0, if_opcode=0, if_funct=0, halted=0, fetch_count=0; this overrides every other input, including mid-handshake and mid-redirect.

Configuration
REQ-029 Macro FETCH_HALT_ON_ZERO_EN defined: in RUN, a capture whose imem_opcode=0 and imem_funct=0 SHALL NOT load the slot; instead FSM -> HALT and pc holds at that address. A slot already valid SHALL remain valid and transfer normally while in HALT.
REQ-030 Macro undefined: an all-zero instruction is fetched and presented like any other; HALT is unreachable and halted is tied to 0.

Verification
REQ-031 Reset, start=1, if_ready=1 held: if_pc sequence 0,4,8,... one per cycle; at pc 0 the slot shows opcode 0, funct 1; fetch_count=10 after 10 transfers.
REQ-032 Backpressure: if_ready=0 for 3 cycles while the slot holds pc 8 -> if_pc stays 8, pc_out stays 12, then resumes 12,16 with no skip or repeat.
REQ-033 Redirect at pc 20 with target 32'h0000_0043 -> if_valid=0 next cycle, then if_pc=0x40; simultaneous redirect+accept counts 1 transfer.
REQ-034 With FETCH_HALT_ON_ZERO_EN, run past address 0x70 (word 28) -> halted=1 with pc_out=0x74, no slot for 0x74; then redirect to 0x50 -> RUN, if_pc=0x50.
REQ-035 rst_n=0 asserted mid-RUN with if_valid=1, if_ready=0 -> next edge all outputs at reset values, IDLE, start required again.
REQ-036 Saturation: force 65536 transfers -> fetch_count=16'hFFFF and holds.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory port, redirect request and the decode output slot.
// The sequencer uses the master modport; the memory/decode environment uses the slave modport.
interface fetch_sequencer_if;
    logic        start;
    logic [31:0] pc_out;
    logic [5:0]  imem_opcode;
    logic [5:0]  imem_funct;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [5:0]  if_opcode;
    logic [5:0]  if_funct;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        input  start, imem_opcode, imem_funct, redirect_valid, redirect_target, if_ready,
        output pc_out, if_valid, if_pc, if_opcode, if_funct, halted, fetch_count
    );

    modport slave (
        output start, imem_opcode, imem_funct, redirect_valid, redirect_target, if_ready,
        input  pc_out, if_valid, if_pc, if_opcode, if_funct, halted, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Purpose: IDLE/RUN/HALT fetch sequencer feeding a one-entry decode slot; FETCH_HALT_ON_ZERO_EN enables halt on an all-zero instruction.
// Latency: instruction at pc_out appears in the slot one cycle later; a redirect costs one empty cycle.
// Backpressure: slot, PC and valid hold while if_valid && !if_ready; redirect flushes the slot regardless.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [5:0]  slot_op_q, slot_op_d;
    logic [5:0]  slot_fn_q, slot_fn_d;
    logic [15:0] cnt_q, cnt_d;

    logic xfer;
    logic slot_free;
    logic halt_hit;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halt_hit = (bus.imem_opcode == 6'd0) && (bus.imem_funct == 6'd0);
`else
    assign halt_hit = 1'b0;
`endif

    assign xfer      = vld_q && bus.if_ready;
    assign slot_free = !vld_q || bus.if_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vld_d     = vld_q;
        slot_pc_d = slot_pc_q;
        slot_op_d = slot_op_q;
        slot_fn_d = slot_fn_q;
        cnt_d     = (xfer && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

        case (state_q)
            IDLE: begin
                // Redirects are meaningless before fetching starts, so only start matters here.
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    pc_d  = bus.redirect_target & ~32'd3;
                    vld_d = 1'b0;
                end else if (slot_free) begin
                    if (halt_hit) begin
                        state_d = HALT;
                        vld_d   = 1'b0;
                    end else begin
                        slot_pc_d = pc_q;
                        slot_op_d = bus.imem_opcode;
                        slot_fn_d = bus.imem_funct;
                        vld_d     = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            HALT: begin
                if (bus.redirect_valid) begin
                    state_d = RUN;
                    pc_d    = bus.redirect_target & ~32'd3;
                    vld_d   = 1'b0;
                end else if (xfer) begin
                    vld_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_ALIGNED;
            vld_q     <= 1'b0;
            slot_pc_q <= 32'd0;
            slot_op_q <= 6'd0;
            slot_fn_q <= 6'd0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            vld_q     <= vld_d;
            slot_pc_q <= slot_pc_d;
            slot_op_q <= slot_op_d;
            slot_fn_q <= slot_fn_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.if_valid    = vld_q;
    assign bus.if_pc       = slot_pc_q;
    assign bus.if_opcode   = slot_op_q;
    assign bus.if_funct    = slot_fn_q;
    assign bus.fetch_count = cnt_q;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign bus.halted = (state_q == HALT);
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transfer-stream scoreboard checked every cycle plus directed literal checks.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rom_hole;
    logic chk_en;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ROM word idx: opcode=idx, funct=idx+1; word 29 (0x74) is all-zero when rom_hole is set.
    function automatic logic [11:0] rom(input logic [5:0] idx, input logic hole);
        logic [5:0] fn;
        fn = idx + 6'd1;
        if (hole && idx == 6'd29) return 12'd0;
        return {idx, fn};
    endfunction

    assign {bus.imem_opcode, bus.imem_funct} = rom(bus.pc_out[7:2], rom_hole);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: transfers must form the address stream implied by sequential fetch and redirects.
    logic        active;
    logic [31:0] exp_next;
    logic [15:0] mcount;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", {16'd0, bus.fetch_count}, {16'd0, mcount});
            chk("m_pc_align", {30'd0, bus.pc_out[1:0]}, 32'd0);
            if (bus.if_valid) begin
                chk("m_slot_insn", {20'd0, bus.if_opcode, bus.if_funct},
                    {20'd0, rom(bus.if_pc[7:2], rom_hole)});
                chk("m_pc_ahead", bus.pc_out, bus.if_pc + 32'd4);
            end
            if (bus.if_valid && bus.if_ready)
                chk("m_order", bus.if_pc, exp_next);
            if (!active) begin
                chk("m_idle_vld", {31'd0, bus.if_valid}, 32'd0);
                chk("m_idle_pc", bus.pc_out, 32'd0);
            end
`ifndef FETCH_HALT_ON_ZERO_EN
            chk("m_halted", {31'd0, bus.halted}, 32'd0);
`endif
        end
        if (!rst_n) begin
            mcount   = 16'd0;
            exp_next = 32'd0;
            active   = 1'b0;
        end else begin
            if (bus.if_valid && bus.if_ready) begin
                if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
                exp_next = bus.if_pc + 32'd4;
            end
            if (active && bus.redirect_valid) exp_next = bus.redirect_target & ~32'd3;
            if (bus.start) active = 1'b1;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc_out"}, bus.pc_out, 32'd0);
        chk({tag, "_vld"}, {31'd0, bus.if_valid}, 32'd0);
        chk({tag, "_if_pc"}, bus.if_pc, 32'd0);
        chk({tag, "_op"}, {26'd0, bus.if_opcode}, 32'd0);
        chk({tag, "_fn"}, {26'd0, bus.if_funct}, 32'd0);
        chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
        chk({tag, "_count"}, {16'd0, bus.fetch_count}, 32'd0);
    endtask

    initial begin
        chk_en              = 1'b0;
        rom_hole            = 1'b1;
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.if_ready        = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk_reset_vals("rst");

        // Straight-line fetch with decode always ready.
        rst_n = 1'b1; bus.start = 1'b1; bus.if_ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t1_first_empty", {31'd0, bus.if_valid}, 32'd0);
        step();
        chk("t1_vld", {31'd0, bus.if_valid}, 32'd1);
        chk("t1_pc0", bus.if_pc, 32'd0);
        chk("t1_op0", {26'd0, bus.if_opcode}, 32'd0);
        chk("t1_fn1", {26'd0, bus.if_funct}, 32'd1);
        chk("t1_pc_out", bus.pc_out, 32'd4);
        repeat (10) step();
        chk("t1_count10", {16'd0, bus.fetch_count}, 32'd10);
        chk("t1_pc28", bus.if_pc, 32'h28);

        // Backpressure while the slot holds pc 8.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step(); step(); step();
        chk("t2_slot8", bus.if_pc, 32'd8);
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_pc", bus.if_pc, 32'd8);
            chk("t2_hold_pc_out", bus.pc_out, 32'd12);
        end
        bus.if_ready = 1'b1;
        step();
        chk("t2_resume12", bus.if_pc, 32'd12);
        step();
        chk("t2_resume16", bus.if_pc, 32'd16);
        chk("t2_count", {16'd0, bus.fetch_count}, 32'd4);

        // Redirect while slot 20 is being accepted.
        step();
        chk("t3_slot20", bus.if_pc, 32'd20);
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0000_0043;
        step();
        bus.redirect_valid = 1'b0;
        chk("t3_flush", {31'd0, bus.if_valid}, 32'd0);
        chk("t3_pc_out", bus.pc_out, 32'h40);
        chk("t3_count", {16'd0, bus.fetch_count}, 32'd6);
        step();
        chk("t3_tgt_vld", {31'd0, bus.if_valid}, 32'd1);
        chk("t3_tgt_pc", bus.if_pc, 32'h40);

        // Run into the all-zero word at 0x74.
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h68;
        step();
        bus.redirect_valid = 1'b0;
        step(); step(); step();
        chk("t4_slot70", bus.if_pc, 32'h70);
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("t4_halted", {31'd0, bus.halted}, 32'd1);
        chk("t4_no_slot", {31'd0, bus.if_valid}, 32'd0);
        chk("t4_pc74", bus.pc_out, 32'h74);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t4_still_halted", {31'd0, bus.halted}, 32'd1);
        chk("t4_still_pc74", bus.pc_out, 32'h74);
`else
        chk("t4_zero_vld", {31'd0, bus.if_valid}, 32'd1);
        chk("t4_zero_pc", bus.if_pc, 32'h74);
        chk("t4_zero_insn", {20'd0, bus.if_opcode, bus.if_funct}, 32'd0);
        step();
        chk("t4_pc78", bus.if_pc, 32'h78);
`endif
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h50;
        step();
        bus.redirect_valid = 1'b0;
        chk("t4_run_again", {31'd0, bus.halted}, 32'd0);
        chk("t4_pc50", bus.pc_out, 32'h50);
        step();
        chk("t4_slot50", bus.if_pc, 32'h50);

        // 32-bit PC wrap.
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFB;
        step();
        bus.redirect_valid = 1'b0;
        chk("t5_pc_fff8", bus.pc_out, 32'hFFFF_FFF8);
        step(); step();
        chk("t5_slot_fffc", bus.if_pc, 32'hFFFF_FFFC);
        chk("t5_wrap0", bus.pc_out, 32'd0);
        step();
        chk("t5_slot0", bus.if_pc, 32'd0);

        // Reset mid-handshake and mid-redirect.
        bus.if_ready = 1'b0;
        step();
        chk("t6_held_vld", {31'd0, bus.if_valid}, 32'd1);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h80;
        step();
        bus.redirect_valid = 1'b0;
        chk_reset_vals("t6");
        rst_n = 1'b1; bus.if_ready = 1'b1;
        repeat (3) step();
        chk("t6_idle_vld", {31'd0, bus.if_valid}, 32'd0);
        chk("t6_idle_pc", bus.pc_out, 32'd0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        chk("t6_restart", bus.if_pc, 32'd0);
        chk("t6_restart_vld", {31'd0, bus.if_valid}, 32'd1);

        // Saturation of the transfer counter.
        rom_hole = 1'b0;
        repeat (65540) step();
        chk("t7_sat", {16'd0, bus.fetch_count}, 32'h0000_FFFF);
        repeat (3) step();
        chk("t7_sat_hold", {16'd0, bus.fetch_count}, 32'h0000_FFFF);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
